// File: rtl/rr_decoder_arbiter_if.sv
// Request/grant bundle between the requesting agents and the round-robin arbiter.
// The master side drives requests; the slave side (the arbiter) returns the grant.
interface rr_decoder_arbiter_if #(
  parameter int NUM_REQ = 8,
  parameter int IDX_W   = 3
);
  logic [NUM_REQ-1:0] req;
  logic               gnt_valid;
  logic [IDX_W-1:0]   gnt_idx;
  logic [NUM_REQ-1:0] gnt_onehot;
  logic               preempt;

  modport master (
    output req,
    input  gnt_valid, gnt_idx, gnt_onehot, preempt
  );

  modport slave (
    input  req,
    output gnt_valid, gnt_idx, gnt_onehot, preempt
  );
endinterface

// File: rtl/rr_decoder_arbiter.sv
// 8-way round-robin arbiter with a registered binary grant, a matching decoded
// one-hot select, and an optional hold limit that forces rotation under contention.
module rr_decoder_arbiter #(
  parameter int NUM_REQ  = 8,
  parameter int IDX_W    = 3,
  parameter int MAX_HOLD = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  rr_decoder_arbiter_if.slave bus
);

  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    last_ptr, last_ptr_nxt;
  logic [HOLD_W-1:0]   hold_cnt, hold_cnt_nxt;
  logic                gnt_valid, gnt_valid_nxt;
  logic [IDX_W-1:0]    gnt_idx, gnt_idx_nxt;
  logic [NUM_REQ-1:0]  gnt_onehot, gnt_onehot_nxt;
  logic                preempt, preempt_nxt;

  logic [NUM_REQ-1:0]  others;
  logic [IDX_W:0]      pick_all, pick_oth;
  logic                limit_hit;

  // First set bit of cand searching upward from ptr+1 with wrap; MSB = found.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] cand,
                                             input logic [IDX_W-1:0]   ptr);
    logic [IDX_W:0]   res;
    logic [IDX_W-1:0] idx;
    res = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = ptr + IDX_W'(i);
      if (cand[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  function automatic logic [NUM_REQ-1:0] decode(input logic en, input logic [IDX_W-1:0] idx);
    return en ? (NUM_REQ'(1) << idx) : '0;
  endfunction

  assign others    = bus.req & ~decode(1'b1, gnt_idx);
  assign pick_all  = rr_pick(bus.req, last_ptr);
  assign pick_oth  = rr_pick(others, last_ptr);
  assign limit_hit = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);

  always_comb begin
    state_nxt      = state;
    last_ptr_nxt   = last_ptr;
    hold_cnt_nxt   = hold_cnt;
    gnt_valid_nxt  = gnt_valid;
    gnt_idx_nxt    = gnt_idx;
    gnt_onehot_nxt = gnt_onehot;
    preempt_nxt    = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_all[IDX_W]) begin
          state_nxt      = GRANT;
          gnt_valid_nxt  = 1'b1;
          gnt_idx_nxt    = pick_all[IDX_W-1:0];
          gnt_onehot_nxt = decode(1'b1, pick_all[IDX_W-1:0]);
          last_ptr_nxt   = pick_all[IDX_W-1:0];
          hold_cnt_nxt   = '0;
        end
      end
      GRANT: begin
        if (!bus.req[gnt_idx]) begin
          // Owner released: hand over in the same edge, or fall back to idle.
          if (pick_all[IDX_W]) begin
            gnt_idx_nxt    = pick_all[IDX_W-1:0];
            gnt_onehot_nxt = decode(1'b1, pick_all[IDX_W-1:0]);
            last_ptr_nxt   = pick_all[IDX_W-1:0];
            hold_cnt_nxt   = '0;
          end else begin
            state_nxt      = IDLE;
            gnt_valid_nxt  = 1'b0;
            gnt_onehot_nxt = '0;
          end
        end else if (limit_hit) begin
          hold_cnt_nxt = '0;
          if (pick_oth[IDX_W]) begin
            gnt_idx_nxt    = pick_oth[IDX_W-1:0];
            gnt_onehot_nxt = decode(1'b1, pick_oth[IDX_W-1:0]);
            last_ptr_nxt   = pick_oth[IDX_W-1:0];
            preempt_nxt    = 1'b1;
          end
        end else if (MAX_HOLD != 0) begin
          hold_cnt_nxt = hold_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_ptr   <= IDX_W'(NUM_REQ - 1);
      hold_cnt   <= '0;
      gnt_valid  <= 1'b0;
      gnt_idx    <= '0;
      gnt_onehot <= '0;
      preempt    <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_ptr   <= last_ptr_nxt;
      hold_cnt   <= hold_cnt_nxt;
      gnt_valid  <= gnt_valid_nxt;
      gnt_idx    <= gnt_idx_nxt;
      gnt_onehot <= gnt_onehot_nxt;
      preempt    <= preempt_nxt;
    end
  end

  assign bus.gnt_valid  = gnt_valid;
  assign bus.gnt_idx    = gnt_idx;
  assign bus.gnt_onehot = gnt_onehot;
  assign bus.preempt    = preempt;

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Directed bench for rr_decoder_arbiter: reset, single grant, fairness rotation,
// hold-limit preemption, lone requester and asynchronous reset mid-grant.
module tb_rr_decoder_arbiter;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  rr_decoder_arbiter_if #(.NUM_REQ(8), .IDX_W(3)) bus ();

  rr_decoder_arbiter #(.NUM_REQ(8), .IDX_W(3), .MAX_HOLD(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req = 8'h00;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic go_idle();
    bus.req = 8'h00;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req = 8'hFF;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({bus.gnt_valid, bus.gnt_onehot, bus.preempt} !== 10'b0) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: got valid=%0b onehot=%h preempt=%0b want 0/00/0",
                 c, bus.gnt_valid, bus.gnt_onehot, bus.preempt);
      end
    end
    checks++;
    if (bus.gnt_idx !== 3'd0) begin
      errors++;
      $display("FAIL reset_idx: got %0d want 0", bus.gnt_idx);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if ({bus.gnt_valid, bus.gnt_idx, bus.gnt_onehot, bus.preempt} !== {1'b1, 3'd0, 8'h01, 1'b0}) begin
      errors++;
      $display("FAIL reset_first_grant: got valid=%0b idx=%0d onehot=%h preempt=%0b want 1/0/01/0",
               bus.gnt_valid, bus.gnt_idx, bus.gnt_onehot, bus.preempt);
    end
  endtask

  task automatic test_single();
    go_idle();
    bus.req = 8'h20;
    tick();
    checks++;
    if ({bus.gnt_valid, bus.gnt_idx, bus.gnt_onehot} !== {1'b1, 3'd5, 8'h20}) begin
      errors++;
      $display("FAIL single_grant: got valid=%0b idx=%0d onehot=%h want 1/5/20",
               bus.gnt_valid, bus.gnt_idx, bus.gnt_onehot);
    end
    bus.req = 8'h00;
    tick();
    checks++;
    if ({bus.gnt_valid, bus.gnt_idx, bus.gnt_onehot} !== {1'b0, 3'd5, 8'h00}) begin
      errors++;
      $display("FAIL single_release: got valid=%0b idx=%0d onehot=%h want 0/5/00",
               bus.gnt_valid, bus.gnt_idx, bus.gnt_onehot);
    end
  endtask

  task automatic test_fairness();
    logic [2:0] nxt;
    logic [7:0] exp_oh;
    do_reset();
    bus.req = 8'hFF;
    tick();
    checks++;
    if ({bus.gnt_valid, bus.gnt_idx, bus.gnt_onehot} !== {1'b1, 3'd0, 8'h01}) begin
      errors++;
      $display("FAIL fair_first: got valid=%0b idx=%0d onehot=%h want 1/0/01",
               bus.gnt_valid, bus.gnt_idx, bus.gnt_onehot);
    end
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if ({bus.gnt_valid, bus.gnt_idx} !== {1'b1, 3'(k)}) begin
        errors++;
        $display("FAIL fair_hold%0d: got valid=%0b idx=%0d want 1/%0d",
                 k, bus.gnt_valid, bus.gnt_idx, k);
      end
      bus.req = 8'hFF & ~(8'h01 << k);
      tick();
      bus.req = 8'hFF;
      nxt    = 3'((k + 1) % 8);
      exp_oh = 8'h01 << nxt;
      checks++;
      if ({bus.gnt_valid, bus.gnt_idx, bus.gnt_onehot, bus.preempt} !== {1'b1, nxt, exp_oh, 1'b0}) begin
        errors++;
        $display("FAIL fair_next%0d: got valid=%0b idx=%0d onehot=%h preempt=%0b want 1/%0d/%h/0",
                 k, bus.gnt_valid, bus.gnt_idx, bus.gnt_onehot, bus.preempt, nxt, exp_oh);
      end
    end
    go_idle();
  endtask

  task automatic test_forced_rotation();
    do_reset();
    bus.req = 8'h09;
    for (int round = 0; round < 3; round++) begin
      logic [2:0] exp_idx;
      exp_idx = (round % 2 == 0) ? 3'd0 : 3'd3;
      for (int c = 0; c < 16; c++) begin
        tick();
        checks++;
        if ({bus.gnt_valid, bus.gnt_idx, bus.gnt_onehot, bus.preempt} !==
            {1'b1, exp_idx, 8'h01 << exp_idx, (round > 0 && c == 0)}) begin
          errors++;
          $display("FAIL forced_r%0d_c%0d: got valid=%0b idx=%0d onehot=%h preempt=%0b want idx=%0d preempt=%0b",
                   round, c, bus.gnt_valid, bus.gnt_idx, bus.gnt_onehot, bus.preempt,
                   exp_idx, (round > 0 && c == 0));
        end
      end
    end
    go_idle();
  endtask

  task automatic test_lone_requester();
    bus.req = 8'h04;
    for (int c = 0; c < 40; c++) begin
      tick();
      checks++;
      if ({bus.gnt_valid, bus.gnt_idx, bus.gnt_onehot, bus.preempt} !== {1'b1, 3'd2, 8'h04, 1'b0}) begin
        errors++;
        $display("FAIL lone_c%0d: got valid=%0b idx=%0d onehot=%h preempt=%0b want 1/2/04/0",
                 c, bus.gnt_valid, bus.gnt_idx, bus.gnt_onehot, bus.preempt);
      end
    end
    go_idle();
  endtask

  task automatic test_reset_mid_grant();
    bus.req = 8'h40;
    tick();
    checks++;
    if ({bus.gnt_valid, bus.gnt_idx} !== {1'b1, 3'd6}) begin
      errors++;
      $display("FAIL midrst_owner: got valid=%0b idx=%0d want 1/6", bus.gnt_valid, bus.gnt_idx);
    end
    repeat (5) tick();
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.gnt_valid, bus.gnt_idx, bus.gnt_onehot, bus.preempt} !== 13'b0) begin
      errors++;
      $display("FAIL midrst_async: got valid=%0b idx=%0d onehot=%h preempt=%0b want all 0",
               bus.gnt_valid, bus.gnt_idx, bus.gnt_onehot, bus.preempt);
    end
    bus.req = 8'h41;
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if ({bus.gnt_valid, bus.gnt_idx, bus.gnt_onehot} !== {1'b1, 3'd0, 8'h01}) begin
      errors++;
      $display("FAIL midrst_first: got valid=%0b idx=%0d onehot=%h want 1/0/01",
               bus.gnt_valid, bus.gnt_idx, bus.gnt_onehot);
    end
    bus.req = 8'h40;
    tick();
    checks++;
    if ({bus.gnt_valid, bus.gnt_idx, bus.gnt_onehot, bus.preempt} !== {1'b1, 3'd6, 8'h40, 1'b0}) begin
      errors++;
      $display("FAIL midrst_second: got valid=%0b idx=%0d onehot=%h preempt=%0b want 1/6/40/0",
               bus.gnt_valid, bus.gnt_idx, bus.gnt_onehot, bus.preempt);
    end
    go_idle();
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    bus.req = 8'h00;
    test_reset();
    test_single();
    test_fairness();
    test_forced_rotation();
    test_lone_requester();
    test_reset_mid_grant();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
